// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built around a single full_adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special slice.
  assign sum_sh_nx = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_sh_nx;
          carry  <= fa_co;
          count  <= count + CW'(1);
          if (count == LAST) begin
            sum  <= sum_sh_nx;
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - table-driven scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;
  localparam int W  = 8;
  localparam int NV = 1006;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  logic         in_valid1 = 1'b0;
  logic         out_ready1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         cin1 = 1'b0;
  logic         in_ready1;
  logic         out_valid1;
  logic [0:0]   sum1;
  logic         cout1;
  logic         busy1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
    int         hold;
    bit         pulse;
  } vec_t;

  vec_t       vecs[NV];
  logic [8:0] sb_q[$];
  logic [8:0] cur_exp = '0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         n_pop = 0;
  int         last_acc = 0;
  int         prev_acc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: expectation queued at accept, compared at the output handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_exp);
        prev_acc = last_acc;
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got 0x%0h expected no output", {cout, sum});
        end else begin
          check("sb_result", {23'd0, cout, sum}, {23'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vcin,
                        input logic [8:0] vexp, input int hold, input bit pulse);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) check("idle_wait", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    cur_exp   = vexp;
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = ~vb; cin = ~vcin;
    k = 0;
    while (!out_valid && k < 100) begin
      if (pulse) begin
        in_valid = 1'b1;
        check("in_ready_run", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      k++;
    end
    check("latency", k, W);
    for (int h = 0; h < hold; h++) begin
      if (pulse) in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_hold", {23'd0, cout, sum}, {23'd0, vexp});
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ov_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int p0;
    int k;
    logic [1:0] e1;

    vecs[0] = '{8'h3C, 8'h15, 1'b0, 9'h051, 0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100, 0, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 0, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 9'h100, 5, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 9'h000, 0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 9'h001, 1, 1'b0};
    for (int i = 6; i < NV; i++) begin
      vecs[i].a     = 8'($urandom_range(0, 255));
      vecs[i].b     = 8'($urandom_range(0, 255));
      vecs[i].cin   = 1'($urandom_range(0, 1));
      vecs[i].exp   = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {8'd0, vecs[i].cin};
      vecs[i].hold  = (i % 7 == 0) ? 2 : 0;
      vecs[i].pulse = (i % 5 == 0);
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum_cout", {23'd0, cout, sum}, 32'd0);
    check("rst_w1_ready", 32'(in_ready1), 32'd1);

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, vecs[i].hold, vecs[i].pulse);

    // Reset in the third RUN cycle discards the in-flight op.
    p0 = n_pop;
    cur_exp = 9'h010;
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_sum_cout", {23'd0, cout, sum}, 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      check("mrst_no_out", 32'(out_valid), 32'd0);
    end
    check("mrst_no_pop", n_pop - p0, 0);
    run_op(8'h02, 8'h03, 1'b0, 9'h005, 0, 1'b0);

    // Back-to-back with in_valid held high.
    p0 = n_pop;
    n0 = n_acc;
    out_ready = 1'b1;
    cur_exp = 9'h030;
    a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
    k = 0;
    while (n_acc < n0 + 1 && k < 20) begin @(posedge clk); #1; k++; end
    check("b2b_acc1", n_acc - n0, 1);
    cur_exp = 9'h080;
    a = 8'h7F; b = 8'h01;
    k = 0;
    while (n_acc < n0 + 2 && k < 50) begin @(posedge clk); #1; k++; end
    in_valid = 1'b0;
    check("b2b_acc2", n_acc - n0, 2);
    check("b2b_gap", last_acc - prev_acc, W + 2);
    k = 0;
    while (n_pop < p0 + 2 && k < 50) begin @(posedge clk); #1; k++; end
    check("b2b_pops", n_pop - p0, 2);

    // WIDTH=1 instance: every input combination, one RUN cycle each.
    for (int v = 0; v < 8; v++) begin
      a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      out_ready1 = 1'b0;
      in_valid1  = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      @(posedge clk); #1;
      check("w1_valid", 32'(out_valid1), 32'd1);
      check("w1_result", {30'd0, cout1, sum1}, {30'd0, e1});
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      check("w1_drop", 32'(out_valid1), 32'd0);
      check("w1_ready", 32'(in_ready1), 32'd1);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that directly consumes the team's FullAdder cell: exactly one FullAdder instance plus a carry flip-flop, two operand shift registers and a sum shift register.
- Accepts a WIDTH-bit operand pair and carry-in through a valid/ready handshake.
- Adds one bit per clock, LSB first, then presents the WIDTH-bit sum and carry-out through a valid/ready output handshake.
- Sits between a register-file/operand source and any result consumer; trades latency for area against a ripple adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair on a/b/cin is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- out_valid  output  1  sum/cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0.
  - Internal carry, bit counter and shift registers cleared.
- rst wins over every other input in the same cycle, including mid-RUN and in DONE. Any in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a rising edge: a_sh<=a, b_sh<=b, carry<=cin, count<=0, next state RUN.
  - Otherwise hold.
  - sum/cout keep their last values.
- RUN:
  - FullAdder inputs are a_sh[0], b_sh[0], carry.
  - Each edge:
    - a_sh and b_sh shift right by one.
    - The FullAdder sum bit shifts into the MSB of sum_sh (sum_sh shifts right).
    - carry<=FullAdder cout.
    - count<=count+1.
  - When count==WIDTH-1 at the edge, next state is DONE; sum<=final sum_sh and cout<=final carry are registered on that same edge.
  - in_ready=0; new in_valid is ignored, not queued.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready at an edge, next state is IDLE.
  - out_valid drops the following cycle.
  - in_ready is 0 in DONE, so there is no same-cycle accept.
- Latency:
  - Operand accept at edge E0; out_valid high after edge E0+WIDTH.
  - Minimum cycle-to-cycle throughput: WIDTH+2 cycles per operation (accept, WIDTH add cycles, one handshake cycle).
- Arithmetic: unsigned modulo 2^WIDTH. cout is the true carry. Signed overflow is not reported.
- Counter width: clog2(WIDTH+1) bits; it never wraps within an operation.
- WIDTH=1: RUN lasts exactly one cycle.
- Back-pressure: out_ready low holds DONE indefinitely with outputs stable.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x3C, b=0x15, cin=0, out_ready=1 -> out_valid rises exactly 8 cycles after accept; sum=0x51, cout=0; in_ready returns 1 the cycle after the handshake.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1 (full carry chain and cin path).
- Back-pressure: a=0x80, b=0x80, cin=0, hold out_ready=0 for 5 cycles -> out_valid stays 1 with sum=0x00, cout=1 stable; the handshake completes on the first out_ready=1 edge. in_valid pulsed during RUN/DONE is ignored (in_ready=0 throughout).
- Reset mid-operation: accept a=0x0F, b=0x01, assert rst at the 3rd RUN cycle -> next cycle state is IDLE, in_ready=1, out_valid=0, sum=0, cout=0. A fresh op a=0x02, b=0x03 then gives sum=0x05.
- Back-to-back: hold in_valid=1 with two queued operand pairs (0x10+0x20, 0x7F+0x01, cin=0), out_ready=1 -> results 0x30 then 0x80, each cout=0, accepts spaced exactly WIDTH+2 cycles apart.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1 after one RUN cycle. Random self-check of 1000 vectors at WIDTH=8 against a+b+cin gives zero mismatches.
